ram_stream_reader: RTL and testbench



---
 rtl/ram_reader_pkg.sv | 28 ++
 rtl/ram_reader_fifo.sv | 62 ++++++
 rtl/ram_stream_reader.sv | 135 +++++++++++++
 tb/tb_ram_stream_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_reader_pkg.sv
// Shared types and constants for the block-RAM stream reader.
package ram_reader_pkg;

  localparam int FIFO_DEPTH         = 3;
  localparam int FIFO_PTR_W         = 2;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic                          last;
  } fifo_entry_t;

  // Circular pointer advance over a non-power-of-two depth.
  function automatic logic [FIFO_PTR_W-1:0] ptr_next(input logic [FIFO_PTR_W-1:0] ptr);
    if (ptr == FIFO_PTR_W'(FIFO_DEPTH - 1)) begin
      return {FIFO_PTR_W{1'b0}};
    end else begin
      return ptr + FIFO_PTR_W'(1);
    end
  endfunction

endpackage

// File: rtl/ram_reader_fifo.sv
// Three-entry elastic buffer between RAM read data and the output stream.
module ram_reader_fifo
  import ram_reader_pkg::*;
#(
  parameter type entry_t = fifo_entry_t
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  entry_t                push_entry,
  input  logic                  pop,
  output entry_t                head_entry,
  output logic                  empty,
  output logic [FIFO_PTR_W-1:0] occupancy
);

  localparam logic [FIFO_PTR_W-1:0] FULL_CNT = FIFO_PTR_W'(FIFO_DEPTH);

  entry_t                mem_r [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_r;
  logic [FIFO_PTR_W-1:0] rd_ptr_r;
  logic [FIFO_PTR_W-1:0] count_r;
  logic                  pop_ok_s;
  logic                  push_ok_s;

  // A push into a full buffer is still accepted when the head leaves in the same cycle.
  always_comb begin
    pop_ok_s  = pop && (count_r != {FIFO_PTR_W{1'b0}});
    push_ok_s = push && ((count_r != FULL_CNT) || pop_ok_s);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {FIFO_PTR_W{1'b0}};
      rd_ptr_r <= {FIFO_PTR_W{1'b0}};
      count_r  <= {FIFO_PTR_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + FIFO_PTR_W'(1);
        2'b01:   count_r <= count_r - FIFO_PTR_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  assign head_entry = mem_r[rd_ptr_r];
  assign empty      = (count_r == {FIFO_PTR_W{1'b0}});
  assign occupancy  = count_r;

endmodule

// File: rtl/ram_stream_reader.sv
// Burst read master for one block-RAM port, emitting a valid/ready stream with last.
// Define RAM_READER_STRIDE_EN to add a per-command address stride (cmd_stride).
module ram_stream_reader
  import ram_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
`ifdef RAM_READER_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
`endif
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  done,
  output logic                  busy
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

  state_e                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LEN_WIDTH-1:0]  remaining_r;
  logic                  inflight_r;
  logic                  inflight_last_r;
  logic [ADDR_WIDTH-1:0] stride_s;
  logic                  accept_s;
  logic                  room_s;
  logic                  issue_s;
  logic                  drain_done_s;
  logic                  fifo_empty_s;
  logic [FIFO_PTR_W-1:0] occupancy_s;
  entry_t                push_entry_s;
  entry_t                head_entry_s;

`ifdef RAM_READER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_r;
  assign stride_s = stride_r;
`else
  assign stride_s = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif

  // Reads are only issued while the buffer plus the read in flight leave a free slot.
  always_comb begin
    accept_s     = cmd_valid && (state_r == IDLE);
    room_s       = ({1'b0, occupancy_s} + {2'b00, inflight_r}) < 3'(FIFO_DEPTH);
    issue_s      = (state_r == READ) && (remaining_r != LEN_ZERO) && room_s;
    drain_done_s = (state_r == DRAIN) && fifo_empty_s && !inflight_r;
    push_entry_s.data = ram_dout;
    push_entry_s.last = inflight_last_r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      addr_r          <= {ADDR_WIDTH{1'b0}};
      remaining_r     <= LEN_ZERO;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
`ifdef RAM_READER_STRIDE_EN
      stride_r        <= {ADDR_WIDTH{1'b0}};
`endif
    end else begin
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s && (remaining_r == LEN_ONE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            addr_r      <= cmd_addr;
            remaining_r <= cmd_len;
`ifdef RAM_READER_STRIDE_EN
            stride_r    <= cmd_stride;
`endif
            state_r     <= (cmd_len != LEN_ZERO) ? READ : DRAIN;
          end
        end
        READ: begin
          if (issue_s) begin
            addr_r      <= addr_r + stride_s;
            remaining_r <= remaining_r - LEN_ONE;
            if (remaining_r == LEN_ONE) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_done_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  ram_reader_fifo #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_r),
    .push_entry (push_entry_s),
    .pop        (m_valid && m_ready),
    .head_entry (head_entry_s),
    .empty      (fifo_empty_s),
    .occupancy  (occupancy_s)
  );

  assign cmd_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign done      = drain_done_s;
  assign ram_en    = issue_s;
  assign ram_addr  = addr_r;
  assign m_valid   = !fifo_empty_s;
  assign m_data    = head_entry_s.data;
  assign m_last    = head_entry_s.last && !fifo_empty_s;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural 1-cycle block RAM.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic [9:0]  cmd_stride;
  logic        ram_en;
  logic [9:0]  ram_addr;
  logic [31:0] ram_dout;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        done;
  logic        busy;

  logic [31:0] mem [1024];
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  int          acc_cyc;
  int          done_cyc;

  logic [9:0]  en_addr_q[$];
  int          en_cyc_q[$];
  logic [31:0] beat_data_q[$];
  logic        beat_last_q[$];
  int          beat_cyc_q[$];
  int          done_cyc_q[$];

  ram_stream_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
`ifdef RAM_READER_STRIDE_EN
    .cmd_stride(cmd_stride),
`endif
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_en) ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_en) begin
        en_addr_q.push_back(ram_addr);
        en_cyc_q.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        beat_data_q.push_back(m_data);
        beat_last_q.push_back(m_last);
        beat_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] exp_word(input logic [9:0] a);
    case (a)
      10'h010: return 32'hA0A0_0010;
      10'h011: return 32'hB0B0_0011;
      10'h012: return 32'hC0C0_0012;
      10'h013: return 32'hD0D0_0013;
      default: return 32'h5A00_0000 | {22'd0, a};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_q();
    en_addr_q.delete();
    en_cyc_q.delete();
    beat_data_q.delete();
    beat_last_q.delete();
    beat_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic issue_cmd(input logic [9:0] a, input logic [10:0] l, input logic [9:0] s);
    @(negedge clk);
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_addr   = a;
    cmd_len    = l;
    cmd_stride = s;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    done_cyc = cyc;
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic post_done(input string tag);
    @(negedge clk);
    chk({tag, "_after_done_flags"}, {done, cmd_ready, busy}, 3'b010);
    chk({tag, "_done_pulses"}, done_cyc_q.size(), 1);
  endtask

  task automatic chk_burst(input string tag, input logic [9:0] base, input int len,
                           input logic [9:0] stride);
    logic [9:0] a;
    chk({tag, "_ren_count"}, en_addr_q.size(), len);
    chk({tag, "_beat_count"}, beat_data_q.size(), len);
    a = base;
    for (int i = 0; i < len; i++) begin
      chk({tag, "_ram_addr"}, en_addr_q[i], a);
      chk({tag, "_m_data"}, beat_data_q[i], exp_word(a));
      chk({tag, "_m_last"}, beat_last_q[i], (i == len - 1));
      a = a + stride;
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 10'd0; cmd_len = 11'd0;
    cmd_stride = 10'd1; m_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = exp_word(10'(i));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_flags", {cmd_ready, ram_en, m_valid, m_last, done, busy}, 6'b100000);
    chk("rst_ram_addr", ram_addr, 10'h000);

    // Basic burst with latency checks
    m_ready = 1'b1;
    clear_q();
    issue_cmd(10'h010, 11'd4, 10'd1);
    wait_done("basic");
    chk_burst("basic", 10'h010, 4, 10'd1);
    chk("basic_beatA", beat_data_q[0], 32'hA0A0_0010);
    chk("basic_beatD", beat_data_q[3], 32'hD0D0_0013);
    chk("basic_ren_first", en_cyc_q[0] - acc_cyc, 0);
    chk("basic_ren_back2back", en_cyc_q[3] - en_cyc_q[0], 3);
    chk("basic_mvalid_first", beat_cyc_q[0] - acc_cyc, 2);
    chk("basic_done_after_last", done_cyc - beat_cyc_q[3], 1);
    post_done("basic");

    // Backpressure: stall 6 cycles, then drain
    m_ready = 1'b0;
    clear_q();
    issue_cmd(10'h100, 11'd8, 10'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3 || i == 5) begin
        chk("bp_stall_valid", {m_valid, m_last}, 2'b10);
        chk("bp_stall_data", m_data, 32'h5A00_0100);
      end
    end
    chk("bp_ren_limited", en_addr_q.size(), 3);
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_done("bp");
    chk_burst("bp", 10'h100, 8, 10'd1);
    post_done("bp");

    // Address wrap
    clear_q();
    issue_cmd(10'h3FE, 11'd4, 10'd1);
    wait_done("wrap");
    chk_burst("wrap", 10'h3FE, 4, 10'd1);
    chk("wrap_addr2", en_addr_q[2], 10'h000);
    post_done("wrap");

    // Empty burst
    clear_q();
    issue_cmd(10'h050, 11'd0, 10'd1);
    @(negedge clk);
    chk("empty_first_cycle", {done, busy, ram_en, m_valid}, 4'b1100);
    post_done("empty");
    chk("empty_no_traffic", en_addr_q.size() + beat_data_q.size(), 0);

    // Reset in the middle of a long burst
    clear_q();
    issue_cmd(10'h200, 11'd16, 10'd1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {m_valid, ram_en, busy, cmd_ready}, 4'b0001);
    clear_q();
    issue_cmd(10'h020, 11'd2, 10'd1);
    wait_done("midrst");
    chk_burst("midrst", 10'h020, 2, 10'd1);
    post_done("midrst");

    // Stride (fixed at 1 without the option)
    clear_q();
    issue_cmd(10'h000, 11'd3, 10'd4);
    wait_done("stride");
`ifdef RAM_READER_STRIDE_EN
    chk_burst("stride", 10'h000, 3, 10'd4);
    chk("stride_addr2", en_addr_q[2], 10'h008);
`else
    chk_burst("stride", 10'h000, 3, 10'd1);
    chk("stride_addr2", en_addr_q[2], 10'h002);
`endif
    post_done("stride");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
